// File: rtl/iiitb_rc_mon.sv
// iiitb_rc_mon: monitors a one-hot ring counter. It checks that each qualified
// sample is the expected rotation of the previous one, counts revolutions
// through the home position, and posts a report per revolution over a
// valid/ready handshake. Sequence or encoding errors are flagged and counted.
`timescale 1ns/1ps
module iiitb_rc_mon #(
  parameter int WIDTH    = 4,
  parameter int ROT_LEFT = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] ring_in,
  input  logic [WIDTH-1:0] home,
  input  logic             clr,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] rpt_data,
  output logic             rpt_ovf,
  output logic [CNT_W-1:0] rev_count,
  output logic             err,
  output logic [7:0]       err_count,
  output logic [1:0]       state_o
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] TRACK = 2'b01;
  localparam logic [1:0] FAULT = 2'b10;

  localparam logic [WIDTH-1:0] RING_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       ERR_MAX  = 8'hFF;

  logic [1:0]       state_q,    state_d;
  logic [WIDTH-1:0] prev_q,     prev_d;
  logic [CNT_W-1:0] revCount_q, revCount_d;
  logic             rptValid_q, rptValid_d;
  logic [CNT_W-1:0] rptData_q,  rptData_d;
  logic             rptOvf_q,   rptOvf_d;
  logic             err_q,      err_d;
  logic [7:0]       errCount_q, errCount_d;

  logic             ringValid;
  logic [WIDTH-1:0] expectedRing;
  logic             postReport;
  logic             errorEvent;
  logic             acceptReport;
  logic [7:0]       errCountBase;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign ringValid = (ring_in != '0) && ((ring_in & (ring_in - RING_ONE)) == '0);

  // Next position of the ring given the direction it is built to rotate.
  assign expectedRing = (ROT_LEFT != 0) ? {prev_q[WIDTH-2:0], prev_q[WIDTH-1]}
                                        : {prev_q[0], prev_q[WIDTH-1:1]};

  assign acceptReport = rptValid_q && rpt_ready;

  // Sequence tracker: decides the next state, stored position, revolution
  // count, and whether this sample posts a report or counts as an error.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    revCount_d = revCount_q;
    postReport = 1'b0;
    errorEvent = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (ringValid) begin
            prev_d  = ring_in;
            state_d = TRACK;
          end else begin
            state_d    = FAULT;
            errorEvent = 1'b1;
          end
        end
        TRACK: begin
          if (ring_in == expectedRing) begin
            prev_d = ring_in;
            if (ring_in == home) begin
              revCount_d = revCount_q + CNT_ONE;
              postReport = 1'b1;
            end
          end else begin
            state_d    = FAULT;
            errorEvent = 1'b1;
          end
        end
        FAULT: begin
          if (ring_in == home) begin
            prev_d  = home;
            state_d = TRACK;
          end else if (!ringValid) begin
            errorEvent = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Report handshake: an accept drops valid, a post (re)loads the newest
  // count; a post onto an unaccepted report marks it as overwritten.
  always_comb begin
    rptValid_d = rptValid_q;
    rptData_d  = rptData_q;
    rptOvf_d   = clr ? 1'b0 : rptOvf_q;
    if (acceptReport) begin
      rptValid_d = 1'b0;
    end
    if (postReport) begin
      rptValid_d = 1'b1;
      rptData_d  = revCount_d;
      if (rptValid_q && !rpt_ready) begin
        rptOvf_d = 1'b1;
      end
    end
  end

  // Error flag and saturating count; a clear applies first so a same-cycle
  // error still lands on top of it.
  always_comb begin
    errCountBase = clr ? 8'h00 : errCount_q;
    err_d        = clr ? 1'b0 : err_q;
    errCount_d   = errCountBase;
    if (errorEvent) begin
      err_d = 1'b1;
      if (errCountBase != ERR_MAX) begin
        errCount_d = errCountBase + 8'd1;
      end
    end
  end

  // All state registers, cleared immediately whenever reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      revCount_q <= '0;
      rptValid_q <= 1'b0;
      rptData_q  <= '0;
      rptOvf_q   <= 1'b0;
      err_q      <= 1'b0;
      errCount_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      revCount_q <= revCount_d;
      rptValid_q <= rptValid_d;
      rptData_q  <= rptData_d;
      rptOvf_q   <= rptOvf_d;
      err_q      <= err_d;
      errCount_q <= errCount_d;
    end
  end

  assign rpt_valid = rptValid_q;
  assign rpt_data  = rptData_q;
  assign rpt_ovf   = rptOvf_q;
  assign rev_count = revCount_q;
  assign err       = err_q;
  assign err_count = errCount_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_iiitb_rc_mon.sv
// Testbench for iiitb_rc_mon (WIDTH=4, ROT_LEFT=1, CNT_W=8, home=0010).
// A reference model predicts the outputs for each driven sample and queues
// them; after the clock edge the prediction is popped and compared.
`timescale 1ns/1ps
module tb_iiitb_rc_mon;

  localparam logic [3:0] HOME = 4'b0010;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       rptReady = 1'b0;
  logic [3:0] ringIn = 4'b0000;
  logic [3:0] home = HOME;
  logic       rptValid;
  logic [7:0] rptData;
  logic       rptOvf;
  logic [7:0] revCount;
  logic       err;
  logic [7:0] errCount;
  logic [1:0] stateO;

  typedef struct {
    logic       rv;
    logic [7:0] rd;
    logic       ovf;
    logic [7:0] rev;
    logic       err;
    logic [7:0] ec;
    logic [1:0] st;
  } expT;

  expT sbQueue[$];

  logic [1:0] mSt;
  logic [3:0] mPrev;
  logic [7:0] mRev;
  logic       mRv;
  logic [7:0] mRd;
  logic       mOvf;
  logic       mErr;
  logic [7:0] mEc;

  int totalChecks = 0;
  int badChecks = 0;

  logic [3:0] revSeq [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] badSeq [4] = '{4'b0000, 4'b1111, 4'b0110, 4'b1010};

  iiitb_rc_mon #(.WIDTH(4), .ROT_LEFT(1), .CNT_W(8)) dut (
    .clk       (clock),
    .reset     (reset),
    .en        (en),
    .ring_in   (ringIn),
    .home      (home),
    .clr       (clr),
    .rpt_ready (rptReady),
    .rpt_valid (rptValid),
    .rpt_data  (rptData),
    .rpt_ovf   (rptOvf),
    .rev_count (revCount),
    .err       (err),
    .err_count (errCount),
    .state_o   (stateO)
  );

  always #5 clock = ~clock;

  // Safety net in case the run stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    totalChecks++;
    if (observed != expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mSt = 2'd0; mPrev = 4'd0; mRev = 8'd0; mRv = 1'b0;
    mRd = 8'd0; mOvf = 1'b0; mErr = 1'b0; mEc = 8'd0;
  endtask

  task automatic modelStep(input logic e, input logic [3:0] r, input logic c, input logic rdy);
    logic       valid;
    logic       post;
    logic       errEv;
    logic       oldRv;
    logic [3:0] nextExp;
    valid   = (r == 4'b0001) || (r == 4'b0010) || (r == 4'b0100) || (r == 4'b1000);
    nextExp = {mPrev[2:0], mPrev[3]};
    post    = 1'b0;
    errEv   = 1'b0;
    if (e) begin
      if (mSt == 2'd0) begin
        if (valid) begin mPrev = r; mSt = 2'd1; end
        else begin mSt = 2'd2; errEv = 1'b1; end
      end else if (mSt == 2'd1) begin
        if (r == nextExp) begin
          mPrev = r;
          if (r == HOME) begin mRev = mRev + 8'd1; post = 1'b1; end
        end else begin
          mSt = 2'd2; errEv = 1'b1;
        end
      end else begin
        if (r == HOME) begin mPrev = HOME; mSt = 2'd1; end
        else if (!valid) errEv = 1'b1;
      end
    end
    if (c) begin mErr = 1'b0; mEc = 8'd0; mOvf = 1'b0; end
    if (errEv) begin
      mErr = 1'b1;
      if (mEc != 8'd255) mEc = mEc + 8'd1;
    end
    oldRv = mRv;
    if (oldRv && rdy) mRv = 1'b0;
    if (post) begin
      if (oldRv && !rdy) mOvf = 1'b1;
      mRv = 1'b1;
      mRd = mRev;
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [3:0] r, input logic c, input logic rdy);
    expT x;
    @(negedge clock);
    en = e; ringIn = r; clr = c; rptReady = rdy;
    modelStep(e, r, c, rdy);
    x.rv = mRv; x.rd = mRd; x.ovf = mOvf; x.rev = mRev;
    x.err = mErr; x.ec = mEc; x.st = mSt;
    sbQueue.push_back(x);
    @(posedge clock);
    #1;
    if (sbQueue.size() == 0) begin
      checkOutput("sb_empty", 0, 1);
    end else begin
      x = sbQueue.pop_front();
      checkOutput("sb_rpt_valid", rptValid, x.rv);
      checkOutput("sb_rpt_data", rptData, x.rd);
      checkOutput("sb_rpt_ovf", rptOvf, x.ovf);
      checkOutput("sb_rev_count", revCount, x.rev);
      checkOutput("sb_err", err, x.err);
      checkOutput("sb_err_count", errCount, x.ec);
      checkOutput("sb_state", stateO, x.st);
    end
  endtask

  task automatic sample(input logic [3:0] r, input logic rdy);
    applyStimulus(1'b1, r, 1'b0, rdy);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rpt_valid"}, rptValid, 0);
    checkOutput({tag, "_rpt_data"}, rptData, 0);
    checkOutput({tag, "_rpt_ovf"}, rptOvf, 0);
    checkOutput({tag, "_rev_count"}, revCount, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_err_count"}, errCount, 0);
    checkOutput({tag, "_state"}, stateO, 0);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic pulseReset(input string tag);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 checkAllZero(tag);
    #1 reset = 1'b1;
    en = 1'b0; clr = 1'b0; rptReady = 1'b0; ringIn = 4'b0000;
    modelReset();
    sbQueue.delete();
  endtask

  initial begin
    modelReset();
    #12;
    checkAllZero("reset");
    reset = 1'b1;

    // One full revolution with the consumer stalled.
    for (int i = 0; i < 5; i++) sample(revSeq[i], 1'b0);
    checkOutput("rev1_rev_count", revCount, 1);
    checkOutput("rev1_rpt_valid", rptValid, 1);
    checkOutput("rev1_rpt_data", rptData, 1);
    checkOutput("rev1_err", err, 0);
    checkOutput("rev1_state", stateO, 1);

    // Second revolution overwrites the pending report.
    for (int i = 1; i < 5; i++) sample(revSeq[i], 1'b0);
    checkOutput("rev2_rpt_data", rptData, 2);
    checkOutput("rev2_rpt_ovf", rptOvf, 1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    checkOutput("rev2_accept_valid", rptValid, 0);

    // Third revolution posts fresh, clr drops overflow, then a fourth post
    // lands in the same cycle as an accept.
    for (int i = 1; i < 5; i++) sample(revSeq[i], 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput("clr_rpt_ovf", rptOvf, 0);
    checkOutput("clr_keeps_valid", rptValid, 1);
    for (int i = 1; i < 4; i++) sample(revSeq[i], 1'b0);
    sample(HOME, 1'b1);
    checkOutput("post_accept_valid", rptValid, 1);
    checkOutput("post_accept_data", rptData, 4);
    checkOutput("post_accept_ovf", rptOvf, 0);

    pulseReset("midrst");

    // Skipped position, recovery at home, then an unchanged sample.
    sample(4'b0010, 1'b0);
    sample(4'b0100, 1'b0);
    sample(4'b0001, 1'b0);
    checkOutput("skip_state", stateO, 2);
    checkOutput("skip_err", err, 1);
    checkOutput("skip_err_count", errCount, 1);
    sample(4'b0010, 1'b0);
    checkOutput("recover_state", stateO, 1);
    checkOutput("recover_rev_count", revCount, 0);
    sample(4'b0100, 1'b0);
    sample(4'b0100, 1'b0);
    checkOutput("stuck_err_count", errCount, 2);

    pulseReset("rst2");

    // Invalid first sample, saturation, clear, clear-with-error.
    sample(4'b0110, 1'b0);
    checkOutput("inv_state", stateO, 2);
    checkOutput("inv_err_count", errCount, 1);
    for (int i = 0; i < 300; i++) sample(badSeq[i % 4], 1'b0);
    checkOutput("sat_err_count", errCount, 255);
    applyStimulus(1'b1, 4'b0100, 1'b1, 1'b0);
    checkOutput("clr_err", err, 0);
    checkOutput("clr_err_count", errCount, 0);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    checkOutput("clr_vs_err", err, 1);
    checkOutput("clr_vs_err_count", errCount, 1);

    pulseReset("rst3");

    // Revolution with en gating every other cycle.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
      sample(revSeq[i], 1'b0);
    end
    checkOutput("gated_rev_count", revCount, 1);
    checkOutput("gated_rpt_valid", rptValid, 1);
    checkOutput("gated_rpt_data", rptData, 1);
    checkOutput("gated_err", err, 0);
    checkOutput("gated_state", stateO, 1);

    // Reset while a report is pending, then the IDLE rules apply again.
    pulseReset("pendrst");
    sample(4'b0100, 1'b0);
    checkOutput("after_rst_state", stateO, 1);
    checkOutput("after_rst_rev_count", revCount, 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/iiitb_rc_mon.md
IIITB_RC_MON -- requirements
Module: iiitb_rc_mon

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the ring width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter ROT_LEFT, default 1: 1 = expected next value {prev[WIDTH-2:0], prev[WIDTH-1]}; 0 = {prev[0], prev[WIDTH-1:1]}.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the revolution counter width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low; 0 SHALL reset all state immediately.
REQ-006 en  input  1  sample qualifier; ring_in SHALL be evaluated only in cycles with en=1.
REQ-007 ring_in  input  WIDTH  one-hot ring counter output under monitor.
REQ-008 home  input  WIDTH  revolution marker position; held static while en=1.
REQ-009 clr  input  1  synchronous clear of err, err_count and rpt_ovf.
REQ-010 rpt_ready  input  1  report consumer ready.
REQ-011 rpt_valid  output  1  revolution report available.
REQ-012 rpt_data  output  CNT_W  revolution count carried by the report.
REQ-013 rpt_ovf  output  1  sticky flag: a report was overwritten before acceptance.
REQ-014 rev_count  output  CNT_W  completed revolutions, wraps modulo 2^CNT_W.
REQ-015 err  output  1  sticky sequence/encoding error flag.
REQ-016 err_count  output  8  error count, saturating at 255.
REQ-017 state_o  output  2  FSM state: 00 IDLE, 01 TRACK, 10 FAULT.

Function
REQ-018 All outputs SHALL be registered; a sample taken at edge N SHALL be reflected in the outputs after edge N.
REQ-019 "Valid" SHALL mean ring_in has exactly one bit set; "expected" SHALL mean the ROT_LEFT rotation of the stored prev.
REQ-020 IDLE, en=1, valid ring_in: the block SHALL store prev<=ring_in, go to TRACK, and leave rev_count unchanged.
REQ-021 IDLE, en=1, invalid ring_in: the block SHALL go to FAULT and count one error.
REQ-022 TRACK, en=1, ring_in==expected: the block SHALL store prev<=ring_in; if ring_in==home, it SHALL increment rev_count and post a report.
REQ-023 TRACK, en=1, ring_in!=expected (including invalid or unchanged): the block SHALL go to FAULT, count one error, and leave prev unchanged.
REQ-024 FAULT, en=1, ring_in==home: the block SHALL store prev<=home, go to TRACK, and leave rev_count unchanged.
REQ-025 FAULT, en=1, invalid ring_in: the block SHALL count one error; a valid non-home sample SHALL be ignored.
REQ-026 Counting one error SHALL set err=1 and increment err_count, saturating at 255.
REQ-027 With en=0, the FSM, prev and counters SHALL hold.
REQ-028 Posting a report SHALL set rpt_valid=1 and rpt_data=new rev_count in the same edge as the increment.
REQ-029 rpt_valid and rpt_data SHALL hold until a cycle with rpt_valid=1 and rpt_ready=1, after which rpt_valid SHALL clear.
REQ-030 A post while rpt_valid=1 and rpt_ready=0 SHALL overwrite rpt_data with the newest count and set rpt_ovf=1.
REQ-031 A post in the same cycle as an accept SHALL keep rpt_valid=1 with the new data and SHALL NOT set rpt_ovf.
REQ-032 clr=1 SHALL zero err, err_count and rpt_ovf; an error or overflow in the same cycle SHALL win (err=1, err_count=1, rpt_ovf=1 as applicable).
REQ-033 clr SHALL NOT affect the FSM, prev, rev_count or the report handshake.

Reset
REQ-034 reset=0 SHALL force state IDLE, prev=0, rev_count=0, rpt_valid=0, rpt_data=0, rpt_ovf=0, err=0 and err_count=0, independent of clk.
REQ-035 Reset asserted mid-operation SHALL discard any pending report; the first en=1 sample after release SHALL be handled per the IDLE rules.

Verification (WIDTH=4, ROT_LEFT=1, CNT_W=8, home=0010)
REQ-036 Samples 0010,0100,1000,0001,0010 with en=1 and rpt_ready=0 -> rev_count=1, rpt_valid=1, rpt_data=1, err=0, state_o=01.
REQ-037 After REQ-036, a second full revolution with rpt_ready=0 -> rpt_data=2, rpt_ovf=1; then rpt_ready=1 for one cycle -> rpt_valid=0.
REQ-038 Samples 0010,0100,0001 -> state_o=10, err=1, err_count=1; then 0010 -> state_o=01 with rev_count unchanged.
REQ-039 A first sample of 0110 from IDLE -> FAULT, err_count=1; 300 further invalid samples -> err_count=255; clr=1 with a valid sample -> err=0, err_count=0.
REQ-040 en toggled 0/1 every other cycle during a revolution -> results identical to REQ-036.
REQ-041 reset pulsed low between clock edges while rpt_valid=1 -> all outputs 0 immediately and state_o=00.
